transpose_scheduler: RTL and testbench

- Shares one matrix transpose datapath between NUM_REQ requesters.
- Arbitrates round-robin and drives the datapath's input select, ctrl and in_val.
- Tracks in-flight operations through a latency-matched pipeline and returns requester id and tag with the datapath result.
- Applies credit-based flow control, because datapath outputs are valid for one cycle only and cannot stall; supports pause/drain for reconfiguration.

---
 rtl/transpose_sched_pkg.sv | 22 ++
 rtl/transpose_scheduler_rr_arbiter.sv | 46 ++++
 rtl/transpose_scheduler.sv | 166 ++++++++++++++++
 tb/tb_transpose_scheduler.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/transpose_sched_pkg.sv
// Shared types for the transpose scheduler: FSM states and the in-flight tracking entry.
// No logic. The entry is sized by the package widths, so the top must use matching NUM_REQ/TAG_W.
package transpose_sched_pkg;

    localparam int SCHED_NUM_REQ = 4;
    localparam int SCHED_TAG_W   = 8;
    localparam int REQ_W         = $clog2(SCHED_NUM_REQ);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        PAUSED = 2'd2
    } sched_state_t;

    typedef struct packed {
        logic                   valid;
        logic [REQ_W-1:0]       id;
        logic [SCHED_TAG_W-1:0] tag;
        logic                   transposed;
    } pipe_entry_t;

endpackage

// File: rtl/transpose_scheduler_rr_arbiter.sv
// Round-robin arbiter: searches from pointer+1, pointer moves to the winner on advance.
// Latency: combinational grant, pointer updates on the clock after advance.
// Backpressure: none; the caller gates the grant and only asserts advance on a real issue.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    localparam int W = $clog2(NUM_REQ)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    input  logic               advance,
    output logic [NUM_REQ-1:0] grant,
    output logic [W-1:0]       index,
    output logic               found
);

    logic [W-1:0] ptr;
    logic [W-1:0] cand;

    always_comb begin
        grant = '0;
        index = '0;
        found = 1'b0;
        cand  = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = W'((int'(ptr) + k) % NUM_REQ);
            if (!found && req[cand]) begin
                found = 1'b1;
                index = cand;
            end
        end
        if (found) begin
            grant[index] = 1'b1;
        end
    end

    // Reset to the last slot so requester 0 is searched first.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= W'(NUM_REQ - 1);
        end else if (advance) begin
            ptr <= index;
        end
    end

endmodule

// File: rtl/transpose_scheduler.sv
// Shares one transpose datapath between requesters; optional perf counters under TRANSPOSE_SCHED_PERF_EN.
// Latency: grant/issue combinational, result tracking returns id/tag DP_LATENCY cycles after issue.
// Backpressure: results cannot stall, so issue is gated by downstream credits and by pause/drain.
module transpose_scheduler
    import transpose_sched_pkg::*;
#(
    parameter int NUM_REQ    = SCHED_NUM_REQ,
    parameter int TAG_W      = SCHED_TAG_W,
    parameter int DP_LATENCY = 1,
    parameter int CREDITS    = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_val,
    input  logic [NUM_REQ-1:0]         req_transpose,
    input  logic [NUM_REQ*TAG_W-1:0]   req_tag,
    output logic [NUM_REQ-1:0]         req_rdy,
    output logic [$clog2(NUM_REQ)-1:0] dp_sel,
    output logic                       dp_ctrl,
    output logic                       dp_in_val,
    input  logic                       dp_out_val,
    output logic                       resp_val,
    output logic [$clog2(NUM_REQ)-1:0] resp_id,
    output logic [TAG_W-1:0]           resp_tag,
    output logic                       resp_transposed,
    input  logic                       credit_ret,
    input  logic                       pause,
    output logic                       pause_ack,
    output logic                       busy,
    output logic [31:0]                perf_issue_cnt,
    output logic [31:0]                perf_stall_cnt
);

    localparam int SW = $clog2(NUM_REQ);
    localparam int CW = $clog2(CREDITS + 1);

    sched_state_t          state_q, state_d;
    logic [CW-1:0]         credits;
    pipe_entry_t           pipe [DP_LATENCY];
    pipe_entry_t           new_entry;
    logic [DP_LATENCY-1:0] vld_vec;
    logic [NUM_REQ-1:0]    grant;
    logic [SW-1:0]         win;
    logic                  found;
    logic                  can_issue;
    logic                  issue;
    logic [SW-1:0]         sel_q;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (req_val),
        .advance (issue),
        .grant   (grant),
        .index   (win),
        .found   (found)
    );

    // dp_ctrl outranks rst inside the datapath, so every issue path is gated by !rst here.
    assign can_issue = !rst && (state_q == RUN) && (credits != '0);
    assign issue     = can_issue && found;
    assign req_rdy   = can_issue ? grant : '0;
    assign dp_in_val = issue;
    assign dp_ctrl   = issue && req_transpose[win];
    assign dp_sel    = issue ? win : sel_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sel_q <= '0;
        end else if (issue) begin
            sel_q <= win;
        end
    end

    always_comb begin
        new_entry = '0;
        if (issue) begin
            new_entry.valid      = 1'b1;
            new_entry.id         = win;
            new_entry.tag        = req_tag[win*TAG_W +: TAG_W];
            new_entry.transposed = req_transpose[win];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < DP_LATENCY; s++) begin
                pipe[s] <= '0;
            end
        end else begin
            pipe[0] <= new_entry;
            for (int s = 1; s < DP_LATENCY; s++) begin
                pipe[s] <= pipe[s-1];
            end
        end
    end

    always_comb begin
        vld_vec = '0;
        for (int s = 0; s < DP_LATENCY; s++) begin
            vld_vec[s] = pipe[s].valid;
        end
    end

    assign busy            = |vld_vec;
    // A result landing in a reset cycle belongs to a discarded op.
    assign resp_val        = pipe[DP_LATENCY-1].valid && !rst;
    assign resp_id         = pipe[DP_LATENCY-1].id;
    assign resp_tag        = pipe[DP_LATENCY-1].tag;
    assign resp_transposed = pipe[DP_LATENCY-1].transposed;

    // Simultaneous issue and return cancel out; returns beyond the pool size are dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            credits <= CW'(CREDITS);
        end else if (issue && !credit_ret) begin
            credits <= credits - CW'(1);
        end else if (credit_ret && !issue && (credits != CW'(CREDITS))) begin
            credits <= credits + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            RUN:     if (pause) state_d = DRAIN;
            DRAIN:   if (!pause) state_d = RUN;
                     else if (!busy) state_d = PAUSED;
            PAUSED:  if (!pause) state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    assign pause_ack = (state_q == PAUSED);

`ifdef TRANSPOSE_SCHED_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_issue_cnt <= '0;
            perf_stall_cnt <= '0;
        end else begin
            if (issue) begin
                perf_issue_cnt <= perf_issue_cnt + 32'd1;
            end
            if ((|req_val) && !issue) begin
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
            end
        end
    end
`else
    assign perf_issue_cnt = '0;
    assign perf_stall_cnt = '0;
`endif

    // The tracking pipe and the datapath must stay in lockstep.
    assert property (@(posedge clk) disable iff (rst) resp_val == dp_out_val);

endmodule

// File: tb/tb_transpose_scheduler.sv
// Directed bench for transpose_scheduler with a one-cycle datapath model feeding dp_out_val.
module tb_transpose_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_val;
    logic [3:0]  req_transpose;
    logic [31:0] req_tag;
    logic [3:0]  req_rdy;
    logic [1:0]  dp_sel;
    logic        dp_ctrl;
    logic        dp_in_val;
    logic        dp_out_val = 1'b0;
    logic        resp_val;
    logic [1:0]  resp_id;
    logic [7:0]  resp_tag;
    logic        resp_transposed;
    logic        credit_ret;
    logic        pause;
    logic        pause_ack;
    logic        busy;
    logic [31:0] perf_issue_cnt;
    logic [31:0] perf_stall_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    always @(posedge clk) dp_out_val <= rst ? 1'b0 : dp_in_val;

    transpose_scheduler dut (
        .clk             (clk),
        .rst             (rst),
        .req_val         (req_val),
        .req_transpose   (req_transpose),
        .req_tag         (req_tag),
        .req_rdy         (req_rdy),
        .dp_sel          (dp_sel),
        .dp_ctrl         (dp_ctrl),
        .dp_in_val       (dp_in_val),
        .dp_out_val      (dp_out_val),
        .resp_val        (resp_val),
        .resp_id         (resp_id),
        .resp_tag        (resp_tag),
        .resp_transposed (resp_transposed),
        .credit_ret      (credit_ret),
        .pause           (pause),
        .pause_ack       (pause_ack),
        .busy            (busy),
        .perf_issue_cnt  (perf_issue_cnt),
        .perf_stall_cnt  (perf_stall_cnt)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic exp_grant(input string t, input int w);
        chk({t, "_rdy"}, 32'(req_rdy), 32'(1 << w));
        chk({t, "_in_val"}, 32'(dp_in_val), 1);
        chk({t, "_sel"}, 32'(dp_sel), w);
    endtask

    task automatic exp_idle(input string t);
        chk({t, "_rdy"}, 32'(req_rdy), 0);
        chk({t, "_in_val"}, 32'(dp_in_val), 0);
        chk({t, "_ctrl"}, 32'(dp_ctrl), 0);
    endtask

    task automatic exp_resp(input string t, input logic v, input int id, input int tg);
        chk({t, "_resp_val"}, 32'(resp_val), 32'(v));
        if (v) begin
            chk({t, "_resp_id"}, 32'(resp_id), id);
            chk({t, "_resp_tag"}, 32'(resp_tag), tg);
        end
    endtask

    initial begin
        rst           = 1'b1;
        req_val       = 4'hF;
        req_transpose = 4'hF;
        req_tag       = {8'h13, 8'h12, 8'h11, 8'h10};
        credit_ret    = 1'b0;
        pause         = 1'b0;

        // Reset with all requesters active and stale transpose requests
        step();
        step();
        #1;
        exp_idle("rst");
        exp_resp("rst", 1'b0, 0, 0);
        chk("rst_resp_id", 32'(resp_id), 0);
        chk("rst_resp_tag", 32'(resp_tag), 0);
        chk("rst_resp_tr", 32'(resp_transposed), 0);
        chk("rst_ack", 32'(pause_ack), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_perf_issue", perf_issue_cnt, 0);
        chk("rst_perf_stall", perf_stall_cnt, 0);

        // Round robin, credits replenished every cycle
        rst           = 1'b0;
        req_transpose = 4'h0;
        credit_ret    = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #1;
            exp_grant("rr", k % 4);
            chk("rr_ctrl", 32'(dp_ctrl), 0);
            exp_resp("rr", k > 0, (k + 3) % 4, 8'h10 + (k + 3) % 4);
            step();
        end
`ifdef TRANSPOSE_SCHED_PERF_EN
        chk("perf_issue", perf_issue_cnt, 5);
        chk("perf_stall", perf_stall_cnt, 0);
`endif

        req_val    = 4'h0;
        credit_ret = 1'b0;
        #1;
        exp_idle("flush");
        exp_resp("flush", 1'b1, 0, 8'h10);
        chk("flush_sel_hold", 32'(dp_sel), 0);
        step();

        // Credit exhaustion: four issues then blocked
        req_val = 4'hF;
        for (int c = 0; c < 4; c++) begin
            #1;
            exp_grant("cr", (c + 1) % 4);
            step();
        end
        #1;
        exp_idle("cr_block");
        exp_resp("cr_block", 1'b1, 0, 8'h10);
        step();
        credit_ret = 1'b1;
        #1;
        exp_idle("cr_block2");
        exp_resp("cr_block2", 1'b0, 0, 0);
        step();
        credit_ret = 1'b0;
        #1;
        exp_grant("cr_one", 1);
        step();
        credit_ret = 1'b1;
        #1;
        exp_idle("cr_zero");
        exp_resp("cr_zero", 1'b1, 1, 8'h11);
        step();
        #1;
        exp_grant("cr_same", 2);
        step();
        credit_ret = 1'b0;
        #1;
        exp_grant("cr_last", 3);
        exp_resp("cr_last", 1'b1, 2, 8'h12);
        step();
        #1;
        exp_idle("cr_empty");
        exp_resp("cr_empty", 1'b1, 3, 8'h13);
        step();

        req_val    = 4'h0;
        credit_ret = 1'b1;
        repeat (5) step();
        credit_ret = 1'b0;

        // Pause raised in the same cycle as an issue
        req_val = 4'b0001;
        pause   = 1'b1;
        #1;
        exp_grant("p0", 0);
        step();
        req_val = 4'hF;
        #1;
        exp_idle("p1");
        exp_resp("p1", 1'b1, 0, 8'h10);
        chk("p1_ack", 32'(pause_ack), 0);
        chk("p1_busy", 32'(busy), 1);
        step();
        #1;
        exp_idle("p2");
        exp_resp("p2", 1'b0, 0, 0);
        chk("p2_ack", 32'(pause_ack), 0);
        chk("p2_busy", 32'(busy), 0);
        step();
        pause = 1'b0;
        #1;
        exp_idle("p3");
        chk("p3_ack", 32'(pause_ack), 1);
        step();
        #1;
        exp_grant("p4", 1);
        chk("p4_ack", 32'(pause_ack), 0);
        step();
        req_val    = 4'h0;
        credit_ret = 1'b1;
        #1;
        exp_resp("p5", 1'b1, 1, 8'h11);
        step();

        // Reset one cycle after an issue discards the op
        credit_ret = 1'b0;
        req_val    = 4'b0100;
        #1;
        exp_grant("r0", 2);
        step();
        rst     = 1'b1;
        req_val = 4'h0;
        #1;
        exp_idle("r1");
        exp_resp("r1", 1'b0, 0, 0);
        step();
        rst = 1'b0;
        #1;
        exp_resp("r2", 1'b0, 0, 0);
        chk("r2_busy", 32'(busy), 0);
        step();
        req_val = 4'hF;
        for (int c = 0; c < 4; c++) begin
            #1;
            exp_grant("r_cr", c);
            step();
        end
        #1;
        exp_idle("r_cr_block");
        exp_resp("r_cr_block", 1'b1, 3, 8'h13);
        step();

        req_val    = 4'h0;
        credit_ret = 1'b1;
        repeat (5) step();
        credit_ret = 1'b0;

        // Transpose op from requester 2
        req_val        = 4'b0100;
        req_transpose  = 4'b0100;
        req_tag[23:16] = 8'hA5;
        #1;
        exp_grant("tr", 2);
        chk("tr_ctrl", 32'(dp_ctrl), 1);
        step();
        req_val       = 4'h0;
        req_transpose = 4'h0;
        #1;
        exp_resp("tr", 1'b1, 2, 8'hA5);
        chk("tr_transposed", 32'(resp_transposed), 1);
        chk("tr_ctrl_off", 32'(dp_ctrl), 0);
        chk("tr_sel_hold", 32'(dp_sel), 2);
        step();
        #1;
        exp_resp("tr_done", 1'b0, 0, 0);
        chk("tr_busy", 32'(busy), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
